sdram_dl_writer: RTL and testbench
==================================

# sdram_dl_writer

ROM-download write front end for one port of the three-port SDRAM controller. It accepts the HPS byte stream, packs even/odd byte pairs into 16-bit words and buffers them in a 4-entry FIFO. It then drives the port's edge-triggered write request against the port's busy flag. It sits between the hps_io download interface and port 0 of the SDRAM controller, and throttles the host with `ioctl_wait`.

## Interface
- `BASE_ADDR`, 22'h0: word offset added to every SDRAM address.
- `FIFO_DEPTH`, 4: buffer entries; must be a power of two, ≥4.
- `clk` in 1: controller clock, same as the SDRAM controller.
- `reset_n` in 1: **one clock; reset is asynchronous and active-low.**
- `ioctl_download` in 1: high for the duration of a download.
- `ioctl_wr` in 1: single-cycle byte strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: host must not strobe while high.
- `sd_addr` out 22: word address to the port (`addr0[22:1]`).
- `sd_din` out 16: write data.
- `sd_wrl` out 1: low-byte write request, level.
- `sd_wrh` out 1: high-byte write request, level.
- `sd_busy` in 1: port busy (`busy0`).
- `done` out 1: one-cycle pulse once all data of a download is written.
- `overrun` out 1: sticky; a strobe arrived while `ioctl_wait` was high, or the address was out of range.

## Operation
- Byte lanes (68k big-endian): `ioctl_addr[0]`=0 → `[15:8]`/wrh; =1 → `[7:0]`/wrl.
- Word address = `ioctl_addr[22:1]` + `BASE_ADDR`, modulo 2^22.
- A strobe with `ioctl_addr[24:23]`≠0 is dropped and sets `overrun`.
- A strobe taken while `ioctl_wait`=1 is dropped and sets `overrun`.
- `overrun` clears only on reset or on a rising edge of `ioctl_download`.
- FIFO entry = {addr22, data16, be2}. Push at most one entry per cycle; pop on `sd_busy` falling edge in WAIT_DONE.
- `ioctl_wait` is registered. It is 1 when FIFO count ≥ FIFO_DEPTH−2, or a pending byte is held, or a flush is in progress.
- Issue FSM:
  - IDLE → REQ when the FIFO is non-empty and `sd_busy`=0.
  - REQ: `sd_addr`/`sd_din` come from the head entry; `{sd_wrh,sd_wrl}`=be. Go to WAIT_DONE when `sd_busy`=1.
  - WAIT_DONE: hold the requests. On `sd_busy` 1→0, pop and go to GAP.
  - GAP: `sd_wrl`=`sd_wrh`=0 for exactly one cycle, so the controller's edge detector re-arms. Then go to IDLE.
- Download end: on `ioctl_download` 1→0, a held byte is pushed as a single-lane entry. `done` pulses one cycle after the FIFO is empty and the FSM has returned to IDLE. There is no `done` if no byte was accepted.
- New `ioctl_download` rise while still draining: draining continues; `done` for the old download is suppressed.

## Timing
- Reset values: all outputs 0; FSM=IDLE; FIFO empty; pack register empty.
- A strobe pushing an entry at edge N gives REQ with `sd_wr*`=1 after edge N+2, provided `sd_busy`=0.
- Requests stay asserted until `sd_busy` falls, even if `sd_busy` rises late because another port holds the controller.
- Minimum spacing between word writes is the controller busy time + 2 cycles (pop/GAP, IDLE).
- FIFO full and a push in the same cycle cannot occur, because `ioctl_wait` leads by 2 entries. Simultaneous push and pop leaves the count unchanged.
- Asynchronous reset mid-transfer: state is lost. After release, the FSM stays in IDLE until `sd_busy`=0 before issuing.

## Configuration
- `SDL_PACK_EN` defined:
  - An even byte is held in the pack register.
  - The next odd byte at the same word address is merged; a full word is pushed with be=11.
  - Any other byte flushes the held byte as be=10. If the new byte is even, it becomes the held byte. If it is odd and belongs to another word, it becomes the pending byte, is pushed next cycle, and holds `ioctl_wait` high meanwhile.
- `SDL_PACK_EN` undefined: every byte is pushed immediately as a single-lane entry (be=10 or 01). The pack and pending registers are not built.

## Test plan
- Pack on; bytes 0x12@0, 0x34@1; BASE=0 → one write: `sd_addr`=0, `sd_din`=0x1234, wrh=wrl=1; `done` pulses after download falls.
- Pack on; bytes @0, @3 → write be=10 addr 0, then be=01 addr 1 with data in `[7:0]`; `ioctl_wait` high one cycle.
- Hold `sd_busy` low for 5 cycles after REQ, then 6 cycles high → wr held throughout, GAP low one cycle, no duplicate write.
- Burst strobes every cycle ignoring `ioctl_wait` → `overrun`=1; writes issued only for accepted bytes, all in order.
- Strobe at `ioctl_addr`=0x1000000 → no write, `overrun`=1. BASE=22'h3FFFFF with byte pair @2 → `sd_addr`=0.
- Assert `reset_n`=0 while in WAIT_DONE, with `sd_busy` staying high for 3 cycles after release → no request until `sd_busy`=0; all outputs 0 during reset.

Source files
------------

// File: rtl/sdram_dl_writer_if.sv
// rtl/sdram_dl_writer_if.sv - hps download stream and sdram port 0 signal bundle
interface sdram_dl_writer_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [21:0] sd_addr;
   logic [15:0] sd_din;
   logic        sd_wrl;
   logic        sd_wrh;
   logic        sd_busy;
   logic        done;
   logic        overrun;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sd_busy,
      input  ioctl_wait, sd_addr, sd_din, sd_wrl, sd_wrh, done, overrun
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sd_busy,
      output ioctl_wait, sd_addr, sd_din, sd_wrl, sd_wrh, done, overrun
   );
endinterface

// File: rtl/sdram_dl_writer.sv
// rtl/sdram_dl_writer.sv - rom download byte packer, fifo and sdram port write issuer (option: SDL_PACK_EN)
module sdram_dl_writer #(
   parameter logic [21:0] BASE_ADDR  = 22'h0,
   parameter int          FIFO_DEPTH = 4
) (
   input logic             clk,
   input logic             reset_n,
   sdram_dl_writer_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 40;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DONE, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          nonempty_q, nonempty_d;
   logic          busy_q, busy_d, dl_q, dl_d;
   logic          wait_q, wait_d, overrun_q, overrun_d, done_q, done_d;
   logic          got_q, got_d, end_q, end_d;
   logic          push, pop, pack_busy, pack_wait;
   logic [EW-1:0] push_entry, head;
   logic          dl_rise, dl_fall, busy_fall, strobe_ok, strobe_bad;
   logic [21:0]   waddr;

`ifdef SDL_PACK_EN
   logic          hold_v_q, hold_v_d, pend_v_q, pend_v_d, flush_q, flush_d;
   logic [21:0]   hold_a_q, hold_a_d, pend_a_q, pend_a_d;
   logic [7:0]    hold_b_q, hold_b_d, pend_b_q, pend_b_d;
`endif

   // Strobe qualification, overrun tracking and building the entry to push this cycle
   always_comb begin
      dl_d       = bus.ioctl_download;
      busy_d     = bus.sd_busy;
      dl_rise    = bus.ioctl_download & ~dl_q;
      dl_fall    = ~bus.ioctl_download & dl_q;
      busy_fall  = busy_q & ~bus.sd_busy;
      strobe_bad = bus.ioctl_wr & (wait_q | (bus.ioctl_addr[24:23] != 2'b00));
      strobe_ok  = bus.ioctl_wr & ~strobe_bad;
      waddr      = bus.ioctl_addr[22:1] + BASE_ADDR;
      overrun_d  = dl_rise ? 1'b0 : overrun_q;
      if (strobe_bad) overrun_d = 1'b1;
      push       = 1'b0;
      push_entry = '0;
`ifdef SDL_PACK_EN
      hold_v_d = hold_v_q;
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      pend_v_d = pend_v_q;
      pend_a_d = pend_a_q;
      pend_b_d = pend_b_q;
      flush_d  = flush_q;
      // ioctl_wait is high whenever pend or flush is active, so no strobe competes with them
      if (pend_v_q) begin
         push       = 1'b1;
         push_entry = {pend_a_q, 8'h00, pend_b_q, 2'b01};
         pend_v_d   = 1'b0;
      end else if (flush_q) begin
         flush_d = 1'b0;
         if (hold_v_q) begin
            push       = 1'b1;
            push_entry = {hold_a_q, hold_b_q, 8'h00, 2'b10};
            hold_v_d   = 1'b0;
         end
      end else if (strobe_ok) begin
         if (hold_v_q) begin
            push = 1'b1;
            if (bus.ioctl_addr[0] && (waddr == hold_a_q)) begin
               push_entry = {hold_a_q, hold_b_q, bus.ioctl_dout, 2'b11};
               hold_v_d   = 1'b0;
            end else begin
               push_entry = {hold_a_q, hold_b_q, 8'h00, 2'b10};
               if (!bus.ioctl_addr[0]) begin
                  hold_a_d = waddr;
                  hold_b_d = bus.ioctl_dout;
               end else begin
                  hold_v_d = 1'b0;
                  pend_v_d = 1'b1;
                  pend_a_d = waddr;
                  pend_b_d = bus.ioctl_dout;
               end
            end
         end else if (!bus.ioctl_addr[0]) begin
            hold_v_d = 1'b1;
            hold_a_d = waddr;
            hold_b_d = bus.ioctl_dout;
         end else begin
            push       = 1'b1;
            push_entry = {waddr, 8'h00, bus.ioctl_dout, 2'b01};
         end
      end
      if (dl_fall) flush_d = 1'b1;
      pack_busy = hold_v_q | pend_v_q | flush_q;
      pack_wait = pend_v_d | flush_d;
`else
      if (strobe_ok) begin
         push       = 1'b1;
         push_entry = bus.ioctl_addr[0] ? {waddr, 8'h00, bus.ioctl_dout, 2'b01}
                                        : {waddr, bus.ioctl_dout, 8'h00, 2'b10};
      end
      pack_busy = 1'b0;
      pack_wait = 1'b0;
`endif
   end

   // Issue FSM: level requests from the head entry, released for one GAP cycle after each write
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      head        = mem_q[rd_ptr_q];
      bus.sd_addr = '0;
      bus.sd_din  = '0;
      bus.sd_wrh  = 1'b0;
      bus.sd_wrl  = 1'b0;
      case (state_q)
         S_IDLE:      if (nonempty_q && !bus.sd_busy) state_d = S_REQ;
         S_REQ:       if (bus.sd_busy) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (busy_fall) begin
                         pop     = 1'b1;
                         state_d = S_GAP;
                      end
         S_GAP:       state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (state_q == S_REQ || state_q == S_WAIT_DONE)
         {bus.sd_addr, bus.sd_din, bus.sd_wrh, bus.sd_wrl} = head;
   end

   // FIFO bookkeeping, host throttle and end-of-download detection
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // nonempty lags count by one cycle so a fresh entry reaches REQ two edges after its push
      nonempty_d = (count_q != '0);
      wait_d     = (int'(count_d) >= FIFO_DEPTH - 2) | pack_wait;
      got_d      = got_q | strobe_ok;
      end_d      = end_q;
      done_d     = 1'b0;
      if (dl_fall && (got_q || strobe_ok)) end_d = 1'b1;
      if (dl_rise) begin
         got_d = strobe_ok;
         end_d = 1'b0;
      end else if (end_q && count_q == '0 && !push && state_q == S_IDLE && !pack_busy) begin
         done_d = 1'b1;
         end_d  = 1'b0;
         got_d  = 1'b0;
      end
   end

   // FIFO storage needs no reset; count and pointers define what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         nonempty_q <= 1'b0;
         busy_q     <= 1'b0;
         dl_q       <= 1'b0;
         wait_q     <= 1'b0;
         overrun_q  <= 1'b0;
         done_q     <= 1'b0;
         got_q      <= 1'b0;
         end_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         nonempty_q <= nonempty_d;
         busy_q     <= busy_d;
         dl_q       <= dl_d;
         wait_q     <= wait_d;
         overrun_q  <= overrun_d;
         done_q     <= done_d;
         got_q      <= got_d;
         end_q      <= end_d;
      end
   end

`ifdef SDL_PACK_EN
   // Pack, pending and flush registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_v_q <= 1'b0;
         hold_a_q <= '0;
         hold_b_q <= '0;
         pend_v_q <= 1'b0;
         pend_a_q <= '0;
         pend_b_q <= '0;
         flush_q  <= 1'b0;
      end else begin
         hold_v_q <= hold_v_d;
         hold_a_q <= hold_a_d;
         hold_b_q <= hold_b_d;
         pend_v_q <= pend_v_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         flush_q  <= flush_d;
      end
   end
`endif

   assign bus.ioctl_wait = wait_q;
   assign bus.overrun    = overrun_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_sdram_dl_writer.sv
// tb/tb_sdram_dl_writer.sv - scoreboard bench for sdram_dl_writer with a port 0 busy model
`timescale 1ns/1ps
module tb_sdram_dl_writer;
   localparam logic [21:0] BASE = 22'h3FFFFF;

   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] din;
      logic [1:0]  be;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sdram_dl_writer_if bus();

   sdram_dl_writer #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   wr_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   bfm_pre = 0;
   int   bfm_len = 3;
   logic bfm_ovr = 1'b0;
   logic bfm_ovr_val = 1'b0;
   int   bfm_phase = 0;
   int   bfm_cnt = 0;
   logic [1:0] bfm_be = 2'b00;
   logic bfm_held = 1'b1;
   logic mon_prev = 1'b0;
   wr_t  mon_got, mon_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic exp_push(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_t w;
      w.addr = a[22:1] + BASE;
      w.din  = d;
      w.be   = be;
      exp_q.push_back(w);
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      @(posedge clk); #1;
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.ioctl_wait && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_release", bus.ioctl_wait, 0);
   endtask

   task automatic start_download();
      bus.ioctl_download = 1'b1;
      @(posedge clk); #1;
      check("overrun_clear_on_start", bus.overrun, 0);
   endtask

   task automatic end_download();
      int start = done_cnt;
      int n = 0;
      bus.ioctl_download = 1'b0;
      while (done_cnt == start && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - start, 1);
   endtask

   // Scoreboard monitor: every new request rise is one write, compared in order
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            mon_prev = 1'b0;
         end else begin
            if ((bus.sd_wrh | bus.sd_wrl) && !mon_prev) begin
               mon_got = {bus.sd_addr, bus.sd_din, bus.sd_wrh, bus.sd_wrl};
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL write_unexpected: got %0h, expected no write", mon_got);
               end else begin
                  mon_exp = exp_q.pop_front();
                  check("write", mon_got, mon_exp);
               end
            end
            mon_prev = bus.sd_wrh | bus.sd_wrl;
            if (bus.done) begin
               done_cnt++;
               check("done_queue_empty", exp_q.size(), 0);
            end
         end
      end
   end

   // Port 0 model: busy after bfm_pre+1 cycles of request, for bfm_len cycles
   initial begin
      bus.sd_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bfm_ovr) begin
            bus.sd_busy = bfm_ovr_val;
            bfm_phase   = 0;
         end else begin
            case (bfm_phase)
               0: begin
                  bus.sd_busy = 1'b0;
                  if (bus.sd_wrh | bus.sd_wrl) begin
                     bfm_be    = {bus.sd_wrh, bus.sd_wrl};
                     bfm_held  = 1'b1;
                     bfm_cnt   = bfm_pre;
                     bfm_phase = 1;
                  end
               end
               1: begin
                  if ({bus.sd_wrh, bus.sd_wrl} != bfm_be) bfm_held = 1'b0;
                  if (bfm_cnt == 0) begin
                     bus.sd_busy = 1'b1;
                     bfm_cnt     = bfm_len;
                     bfm_phase   = 2;
                  end else begin
                     bfm_cnt--;
                  end
               end
               2: begin
                  if ({bus.sd_wrh, bus.sd_wrl} != bfm_be) bfm_held = 1'b0;
                  bfm_cnt--;
                  if (bfm_cnt == 0) begin
                     bus.sd_busy = 1'b0;
                     bfm_phase   = 3;
                  end
               end
               default: begin
                  check("gap_low", {bus.sd_wrh, bus.sd_wrl}, 0);
                  check("wr_held", bfm_held, 1);
                  bfm_phase = 0;
               end
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   n;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {bus.ioctl_wait, bus.sd_wrl, bus.sd_wrh, bus.done, bus.overrun,
                              bus.sd_addr, bus.sd_din}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_outputs", {bus.ioctl_wait, bus.sd_wrl, bus.sd_wrh, bus.done, bus.overrun}, 0);

      // Byte pair 0x12@0, 0x34@1
      start_download();
`ifdef SDL_PACK_EN
      exp_push(25'h0, 16'h1234, 2'b11);
`else
      exp_push(25'h0, 16'h1200, 2'b10);
      exp_push(25'h1, 16'h0034, 2'b01);
`endif
      strobe(25'h0, 8'h12);
      strobe(25'h1, 8'h34);
      end_download();
      check("overrun_after_pair", bus.overrun, 0);

      // Bytes @0 and @3 land in different words
      start_download();
      exp_push(25'h0, 16'hAB00, 2'b10);
      exp_push(25'h3, 16'h00CD, 2'b01);
      strobe(25'h0, 8'hAB);
      strobe(25'h3, 8'hCD);
      check("wait_after_split", bus.ioctl_wait, 1);
      end_download();

      // Late busy: request held 5 cycles before busy, busy 6 cycles; pair @2 wraps to word 0
      bfm_pre = 4;
      bfm_len = 6;
      start_download();
`ifdef SDL_PACK_EN
      exp_push(25'h2, 16'h5566, 2'b11);
`else
      exp_push(25'h2, 16'h5500, 2'b10);
      exp_push(25'h3, 16'h0066, 2'b01);
`endif
      strobe(25'h2, 8'h55);
      strobe(25'h3, 8'h66);
      end_download();
      bfm_pre = 0;
      bfm_len = 3;

      // Burst every cycle ignoring ioctl_wait
      start_download();
      wait_ready();
      for (int i = 0; i < 8; i++) begin
         acc = ~bus.ioctl_wait;
         if (acc) exp_push(25'(2 * i + 1), {8'h00, 8'(8'h80 + i)}, 2'b01);
         strobe(25'(2 * i + 1), 8'(8'h80 + i));
      end
      check("overrun_burst", bus.overrun, 1);
      end_download();

      // Out-of-range address is dropped
      start_download();
      wait_ready();
      strobe(25'h1000000, 8'h77);
      check("overrun_range", bus.overrun, 1);
      wait_ready();
      exp_push(25'h5, 16'h0099, 2'b01);
      strobe(25'h5, 8'h99);
      end_download();

      // Reset while a write waits for busy to fall
      bfm_len = 20;
      bus.ioctl_download = 1'b1;
      @(posedge clk); #1;
      exp_push(25'h9, 16'h0042, 2'b01);
      strobe(25'h9, 8'h42);
      n = 0;
      while (!bus.sd_busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_seen", bus.sd_busy, 1);
      @(posedge clk); #1;
      bfm_ovr_val = 1'b1;
      bfm_ovr     = 1'b1;
      #2 reset_n = 1'b0;
      bus.ioctl_download = 1'b0;
      #1;
      check("reset_mid_outputs", {bus.ioctl_wait, bus.sd_wrl, bus.sd_wrh, bus.done, bus.overrun,
                                  bus.sd_addr, bus.sd_din}, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold_outputs", {bus.sd_wrl, bus.sd_wrh, bus.done}, 0);
      reset_n = 1'b1;
      bfm_len = 3;
      bus.ioctl_download = 1'b1;
      exp_push(25'h11, 16'h0024, 2'b01);
      strobe(25'h11, 8'h24);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("no_req_while_busy", {bus.sd_wrh, bus.sd_wrl}, 0);
      end
      bfm_ovr = 1'b0;
      end_download();

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
